// File: rtl/semaforo_ctrl_pkg.sv
// Shared state encoding, default phase durations and the fast-speed duration rule
// for the traffic-light controller and its bench.
package semaforo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ROJO     = 2'd1,
    VERDE    = 2'd2,
    AMARILLO = 2'd3
  } state_t;

  localparam int T_ROJO_DEF     = 8;
  localparam int T_VERDE_DEF    = 6;
  localparam int T_AMARILLO_DEF = 2;
  localparam int CNT_W_DEF      = 8;

  // Fast speed halves a duration but never drops it below one cycle.
  function automatic int dur(input int t, input logic vel);
    int h;
    h = t >> 1;
    if (!vel) return t;
    return (h < 1) ? 1 : h;
  endfunction

endpackage

// File: rtl/semaforo_timer.sv
// Loadable down-counter that saturates at zero; done flags the final cycle of a phase.
// Load wins over the decrement so a phase entry always restarts the count.
module semaforo_timer #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RESET)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/semaforo_ctrl.sv
// Traffic-light sequencer ROJO -> VERDE -> AMARILLO while START is held; VEL picks
// halved durations, sampled on the edge that enters each phase.
module semaforo_ctrl
  import semaforo_ctrl_pkg::*;
#(
  parameter int T_ROJO     = T_ROJO_DEF,
  parameter int T_VERDE    = T_VERDE_DEF,
  parameter int T_AMARILLO = T_AMARILLO_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic START,
  input  logic VEL,
  output logic LUZ_ROJA,
  output logic LUZ_VERDE,
  output logic LUZ_AMARILLA
);

  state_t           state;
  state_t           nxt_state;
  logic             load;
  logic             done;
  logic [CNT_W-1:0] load_val;

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:     if (START) nxt_state = ROJO;
      ROJO:     if (done)  nxt_state = VERDE;
      VERDE:    if (done)  nxt_state = AMARILLO;
      AMARILLO: if (done)  nxt_state = START ? ROJO : IDLE;
      default:             nxt_state = IDLE;
    endcase
  end

  // Timer reloads only when a lit phase is entered; IDLE leaves it parked at zero.
  always_comb begin
    load     = (nxt_state != state) && (nxt_state != IDLE);
    load_val = '0;
    case (nxt_state)
      ROJO:     load_val = CNT_W'(dur(T_ROJO, VEL) - 1);
      VERDE:    load_val = CNT_W'(dur(T_VERDE, VEL) - 1);
      AMARILLO: load_val = CNT_W'(dur(T_AMARILLO, VEL) - 1);
      default:  load_val = '0;
    endcase
  end

  semaforo_timer #(.CNT_W(CNT_W)) u_timer (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  // Lamps decode the next state so they line up with the state register, no extra cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      LUZ_ROJA     <= 1'b1;
      LUZ_VERDE    <= 1'b0;
      LUZ_AMARILLA <= 1'b0;
    end else begin
      state        <= nxt_state;
      LUZ_ROJA     <= (nxt_state == IDLE) || (nxt_state == ROJO);
      LUZ_VERDE    <= (nxt_state == VERDE);
      LUZ_AMARILLA <= (nxt_state == AMARILLO);
    end
  end

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Bench for semaforo_ctrl: phase-countdown reference model checked every cycle, plus
// literal lamp run lengths for the directed scenarios and a randomized tail.
module tb_semaforo_ctrl;
  import semaforo_ctrl_pkg::*;

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_G = 3'b010;
  localparam logic [2:0] L_Y = 3'b001;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       vel;
  logic       luz_r, luz_v, luz_a;
  logic [2:0] lamps;

  int checks   = 0;
  int failures = 0;
  int reds;

  semaforo_ctrl dut (
    .CLK          (clk),
    .RESET        (reset),
    .START        (start),
    .VEL          (vel),
    .LUZ_ROJA     (luz_r),
    .LUZ_VERDE    (luz_v),
    .LUZ_AMARILLA (luz_a)
  );

  always #5 clk = ~clk;
  assign lamps = {luz_r, luz_v, luz_a};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: phase index plus cycles remaining in that phase (counting the current one).
  function automatic int eff(input int t, input logic v);
    if (!v) return t;
    if (t / 2 == 0) return 1;
    return t / 2;
  endfunction

  int m_st    = 0;
  int m_rem   = 0;
  bit m_valid = 0;

  always @(posedge clk) begin : model
    int st, rem;
    st  = m_st;
    rem = m_rem;
    if (reset) begin
      st  = 0;
      rem = 0;
    end else if (st == 0) begin
      if (start) begin st = 1; rem = eff(T_ROJO_DEF, vel); end
    end else begin
      rem = rem - 1;
      if (rem == 0) begin
        if (st == 1) begin st = 2; rem = eff(T_VERDE_DEF, vel); end
        else if (st == 2) begin st = 3; rem = eff(T_AMARILLO_DEF, vel); end
        else if (start) begin st = 1; rem = eff(T_ROJO_DEF, vel); end
        else st = 0;
      end
    end
    m_st  <= st;
    m_rem <= rem;
    if (reset) m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("lamps_vs_model", lamps, (m_st == 2) ? L_G : (m_st == 3) ? L_Y : L_R);
      check("one_hot", $countones(lamps), 1);
    end
  end

  // Waits for lamp l, then counts its consecutive cycles; returns on the next phase's first cycle.
  task automatic run(input logic [2:0] l, input int pre, input int exp, input string name);
    int n, cnt;
    n   = 0;
    cnt = pre;
    while (lamps != l && n < 60) begin @(negedge clk); n++; end
    if (lamps != l) begin
      check({name, "_timeout"}, lamps, l);
      return;
    end
    while (lamps == l && cnt < 100) begin cnt++; @(negedge clk); end
    check(name, cnt, exp);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; vel = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_red", lamps, L_R);
    reset = 1'b0;

    reds = 0;
    repeat (20) begin @(negedge clk); if (lamps == L_R) reds++; end
    check("idle_20_red", reds, 20);

    start = 1'b1;
    @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      run(L_R, 0, 8, "norm_r");
      run(L_G, 0, 6, "norm_g");
      run(L_Y, 0, 2, "norm_y");
    end

    // VEL rises during the first red cycle: that red was already entered at normal speed.
    vel = 1'b1;
    run(L_R, 0, 8, "vel_late_r");
    run(L_G, 0, 3, "fast_g1");
    run(L_Y, 0, 1, "fast_y1");
    run(L_R, 0, 4, "fast_r2");
    run(L_G, 0, 3, "fast_g2");
    run(L_Y, 0, 1, "fast_y2");

    vel = 1'b0;
    run(L_R, 0, 4, "fast_r3");
    @(negedge clk);
    vel = 1'b1;
    run(L_G, 1, 6, "tog_g");
    run(L_Y, 0, 1, "tog_y");
    run(L_R, 0, 4, "tog_r");

    start = 1'b0; vel = 1'b0;
    run(L_G, 0, 3, "drop_g");
    run(L_Y, 0, 2, "drop_y");
    reds = 0;
    repeat (10) begin if (lamps == L_R) reds++; @(negedge clk); end
    check("park_red", reds, 10);

    start = 1'b1;
    @(negedge clk);
    run(L_R, 0, 8, "restart_r");
    run(L_G, 0, 6, "restart_g");

    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_yellow", lamps, L_R);
    reset = 1'b0; start = 1'b1; vel = 1'b1;
    @(negedge clk);
    run(L_R, 0, 4, "rst_fast_r");
    run(L_G, 0, 3, "rst_fast_g");
    run(L_Y, 0, 1, "rst_fast_y");
    run(L_R, 0, 4, "rst_fast_r2");

    repeat (800) begin
      @(negedge clk);
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) start = ~start;
      if ($urandom_range(0, 9) == 0) vel = 1'($urandom_range(0, 1));
    end
    reset = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
